// File: rtl/bridge_pkg.sv
// Shared types and constants for the 8086 byte-serialising memory bridge.
// Used by bus_bridge16 and bridge_perf_cnt.
package bridge_pkg;
  localparam int ADDR_W_DEF = 20;
  localparam int LAT_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } state_e;
endpackage

// File: rtl/bridge_perf_cnt.sv
// Free-running count of completed bridge accesses (one per done pulse).
// Only instantiated when BUS_BRIDGE_PERF_EN is defined.
import bridge_pkg::*;

module bridge_perf_cnt (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        done,
  output logic [31:0] perf_count
);
  logic [31:0] count_q;
  logic [31:0] count_d;

  assign count_d = done ? count_q + 32'd1 : count_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign perf_count = count_q;
endmodule

// File: rtl/bus_bridge16.sv
// 8/16-bit core request to 8-bit synchronous memory serialiser.
// Define BUS_BRIDGE_PERF_EN to add the perf_count completed-access counter.
import bridge_pkg::*;

module bus_bridge16 #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              wr,
  input  logic              word,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata,
  output logic              busy,
  output logic              done,
`ifdef BUS_BRIDGE_PERF_EN
  output logic [31:0]       perf_count,
`endif
  output logic [ADDR_W-1:0] mem_address,
  input  logic [7:0]        mem_i_data,
  output logic [7:0]        mem_o_data,
  output logic              mem_we
);
  state_e state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic wr_q, wr_d;
  logic word_q, word_d;
  logic [7:0] whi_q, whi_d;
  logic [7:0] lo_q, lo_d;
  logic [15:0] rdata_q, rdata_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0] wdo_q, wdo_d;
  logic we_q, we_d;
  logic last;
  logic lat_hit;

  assign last = (state_q == HI) || !word_q;
  assign lat_hit = (cnt_q == LAT_W'(RD_LAT));

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    wr_d = wr_q;
    word_d = word_q;
    whi_d = whi_q;
    lo_d = lo_q;
    rdata_d = rdata_q;
    busy_d = busy_q;
    done_d = 1'b0;
    addr_d = addr_q;
    wdo_d = wdo_q;
    we_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LO;
          busy_d = 1'b1;
          cnt_d = '0;
          wr_d = wr;
          word_d = word;
          whi_d = wdata[15:8];
          addr_d = addr;
          wdo_d = wdata[7:0];
          we_d = wr;
        end
      end
      LO, HI: begin
        if (wr_q) begin
          // final write byte holds one settle clock before done
          if (!last) begin
            state_d = HI;
            addr_d = addr_q + 1'b1;
            wdo_d = whi_q;
            we_d = 1'b1;
          end else if (cnt_q == '0) begin
            cnt_d = LAT_W'(1);
          end else begin
            state_d = DONE;
            done_d = 1'b1;
          end
        end else if (!lat_hit) begin
          cnt_d = cnt_q + 1'b1;
        end else if (!last) begin
          lo_d = mem_i_data;
          state_d = HI;
          addr_d = addr_q + 1'b1;
          cnt_d = '0;
        end else begin
          state_d = DONE;
          done_d = 1'b1;
          rdata_d = word_q ? {mem_i_data, lo_q}
                           : {8'h00, mem_i_data};
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wr_q <= 1'b0;
      word_q <= 1'b0;
      whi_q <= '0;
      lo_q <= '0;
      rdata_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      addr_q <= '0;
      wdo_q <= '0;
      we_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wr_q <= wr_d;
      word_q <= word_d;
      whi_q <= whi_d;
      lo_q <= lo_d;
      rdata_q <= rdata_d;
      busy_q <= busy_d;
      done_q <= done_d;
      addr_q <= addr_d;
      wdo_q <= wdo_d;
      we_q <= we_d;
    end
  end

  assign rdata = rdata_q;
  assign busy = busy_q;
  assign done = done_q;
  assign mem_address = addr_q;
  assign mem_o_data = wdo_q;
  assign mem_we = we_q;

`ifdef BUS_BRIDGE_PERF_EN
  bridge_perf_cnt u_perf (
    .clock      (clock),
    .reset_n    (reset_n),
    .done       (done_q),
    .perf_count (perf_count)
  );
`endif
endmodule

// File: tb/tb_bus_bridge16.sv
// Directed bench for bus_bridge16 against a byte RAM model.
// Second instance covers RD_LAT=3.
module tb_bus_bridge16;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic wr = 1'b0;
  logic word = 1'b0;
  logic [19:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic busy;
  logic done;
  logic [19:0] mem_address;
  logic [7:0] mem_i_data;
  logic [7:0] mem_o_data;
  logic mem_we;

  logic start3 = 1'b0;
  logic [19:0] addr3 = '0;
  logic [15:0] rdata3;
  logic busy3;
  logic done3;
  logic [19:0] m3_addr;
  logic [7:0] m3_rd;
  logic [7:0] m3_wd;
  logic m3_we;

`ifdef BUS_BRIDGE_PERF_EN
  logic [31:0] perf_count;
  logic [31:0] perf3;
`endif

  logic [7:0] ram [0:1048575];
  logic [7:0] rd1;
  logic [7:0] r3a, r3b, r3c;
  logic pre_we = 1'b0;
  logic [19:0] pre_a = '0;
  logic [7:0] pre_d = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bus_bridge16 #(.ADDR_W(20), .RD_LAT(1)) dut (
    .clock(clk), .reset_n(reset_n), .start(start), .wr(wr),
    .word(word), .addr(addr), .wdata(wdata), .rdata(rdata),
    .busy(busy), .done(done),
`ifdef BUS_BRIDGE_PERF_EN
    .perf_count(perf_count),
`endif
    .mem_address(mem_address), .mem_i_data(mem_i_data),
    .mem_o_data(mem_o_data), .mem_we(mem_we)
  );

  bus_bridge16 #(.ADDR_W(20), .RD_LAT(3)) dut3 (
    .clock(clk), .reset_n(reset_n), .start(start3), .wr(1'b0),
    .word(1'b0), .addr(addr3), .wdata(16'h0000), .rdata(rdata3),
    .busy(busy3), .done(done3),
`ifdef BUS_BRIDGE_PERF_EN
    .perf_count(perf3),
`endif
    .mem_address(m3_addr), .mem_i_data(m3_rd),
    .mem_o_data(m3_wd), .mem_we(m3_we)
  );

  always @(posedge clk) begin
    if (pre_we) ram[pre_a] <= pre_d;
    else if (mem_we) ram[mem_address] <= mem_o_data;
    rd1 <= ram[mem_address];
    r3a <= ram[m3_addr];
    r3b <= r3a;
    r3c <= r3b;
  end
  assign mem_i_data = rd1;
  assign m3_rd = r3c;

  task automatic preload(input logic [19:0] a, input logic [7:0] d);
    pre_a = a;
    pre_d = d;
    pre_we = 1'b1;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  // Start at edge N; k = clocks after N until done is seen.
  task automatic run_access(input logic w, input logic wd,
                            input logic [19:0] a, input logic [15:0] d,
                            output int k, output int wen);
    @(posedge clk); #1;
    wr = w; word = wd; addr = a; wdata = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    wen = 0;
    while (!done && k < 20) begin
      if (mem_we) wen++;
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #3;
    tests++;
    if ({rdata, busy, done, mem_address, mem_o_data, mem_we} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got rdata=%h busy=%b done=%b addr=%h wd=%h we=%b want all 0",
               rdata, busy, done, mem_address, mem_o_data, mem_we);
    end
    preload(20'hF8000, 8'hEA);
    preload(20'hF8001, 8'h5B);
    preload(20'hFFFFF, 8'h00);
    preload(20'h00000, 8'h00);
    preload(20'h00100, 8'h00);
    preload(20'h00101, 8'h77);
    preload(20'h00200, 8'h55);
    reset_n = 1'b1;
  endtask

  task automatic test_word_read;
    int k, wen;
    run_access(1'b0, 1'b1, 20'hF8000, 16'h0000, k, wen);
    tests++;
    if (k !== 4) begin fails++; $display("FAIL wrd_done_cycle got %0d want 4", k); end
    tests++;
    if (rdata !== 16'h5BEA) begin fails++; $display("FAIL wrd_rdata got %h want 5bea", rdata); end
    tests++;
    if (wen !== 0) begin fails++; $display("FAIL wrd_mem_we got %0d want 0", wen); end
  endtask

  task automatic test_byte_read;
    int k, wen;
    run_access(1'b0, 1'b0, 20'hF8001, 16'h0000, k, wen);
    tests++;
    if (k !== 2) begin fails++; $display("FAIL brd_done_cycle got %0d want 2", k); end
    tests++;
    if (rdata !== 16'h005B) begin fails++; $display("FAIL brd_rdata got %h want 005b", rdata); end
  endtask

  task automatic test_wrap_write;
    int k, wen;
    run_access(1'b1, 1'b1, 20'hFFFFF, 16'h1234, k, wen);
    tests++;
    if (k !== 3) begin fails++; $display("FAIL wwr_done_cycle got %0d want 3", k); end
    tests++;
    if (wen !== 2) begin fails++; $display("FAIL wwr_we_clocks got %0d want 2", wen); end
    tests++;
    if (ram[20'hFFFFF] !== 8'h34) begin
      fails++; $display("FAIL wwr_lo got %h want 34", ram[20'hFFFFF]);
    end
    tests++;
    if (ram[20'h00000] !== 8'h12) begin
      fails++; $display("FAIL wwr_hi_wrap got %h want 12", ram[20'h00000]);
    end
  endtask

  task automatic test_back_to_back;
    int k, wen, extra;
    @(posedge clk); #1;
    wr = 1'b0; word = 1'b1; addr = 20'hF8000; start = 1'b1;
    @(posedge clk); #1;
    wr = 1'b1; addr = 20'h00200; wdata = 16'hFFFF;
    k = 0;
    wen = 0;
    while (!done && k < 20) begin
      if (mem_we) wen++;
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
    start = 1'b0;
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      if (done || mem_we || busy) extra++;
      @(posedge clk); #1;
    end
    tests++;
    if (k !== 4) begin fails++; $display("FAIL b2b_done_cycle got %0d want 4", k); end
    tests++;
    if (wen !== 0) begin fails++; $display("FAIL b2b_mem_we got %0d want 0", wen); end
    tests++;
    if (extra !== 0) begin fails++; $display("FAIL b2b_ignored_start got %0d want 0", extra); end
    tests++;
    if (ram[20'h00200] !== 8'h55) begin
      fails++; $display("FAIL b2b_ram got %h want 55", ram[20'h00200]);
    end
    tests++;
    if (rdata !== 16'h5BEA) begin fails++; $display("FAIL b2b_rdata got %h want 5bea", rdata); end
    run_access(1'b0, 1'b0, 20'hF8000, 16'h0000, k, wen);
    tests++;
    if (k !== 2 || rdata !== 16'h00EA) begin
      fails++; $display("FAIL b2b_next got k=%0d rdata=%h want 2 00ea", k, rdata);
    end
`ifdef BUS_BRIDGE_PERF_EN
    tests++;
    if (perf_count !== 32'd5) begin
      fails++; $display("FAIL perf_count got %0d want 5", perf_count);
    end
`endif
  endtask

  task automatic test_reset_abort;
    int seen;
    @(posedge clk); #1;
    wr = 1'b1; word = 1'b1; addr = 20'h00100; wdata = 16'hABCD; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (mem_we !== 1'b1 || mem_address !== 20'h00101) begin
      fails++; $display("FAIL rst_hi_phase got we=%b addr=%h want 1 00101", mem_we, mem_address);
    end
    #2;
    reset_n = 1'b0;
    #1;
    tests++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL rst_async got we=%b busy=%b done=%b want 0 0 0", mem_we, busy, done);
    end
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    tests++;
    if (seen !== 0) begin fails++; $display("FAIL rst_no_done got %0d want 0", seen); end
    tests++;
    if (ram[20'h00100] !== 8'hCD || ram[20'h00101] !== 8'h77) begin
      fails++; $display("FAIL rst_ram got %h %h want cd 77", ram[20'h00100], ram[20'h00101]);
    end
  endtask

  task automatic test_lat3;
    int k;
    @(posedge clk); #1;
    addr3 = 20'hF8000; start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    k = 0;
    while (!done3 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    tests++;
    if (k !== 4) begin fails++; $display("FAIL lat3_done_cycle got %0d want 4", k); end
    tests++;
    if (rdata3 !== 16'h00EA) begin fails++; $display("FAIL lat3_rdata got %h want 00ea", rdata3); end
  endtask

  initial begin
    test_reset();
    test_word_read();
    test_byte_read();
    test_wrap_write();
    test_back_to_back();
    test_reset_abort();
    test_lat3();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
